sum_stage: RTL and testbench

Pipeline stage directly downstream of the PE multiply stage. Per PE row it adds the registered multiplier sum to a partial sum, either the incoming psum or an internal accumulator, across one or more beats. It saturates or wraps per control and emits one result beat, plus the pass-through pipe control, to the psum-pack stage on the last beat of an accumulation. All stage transfers use the codebase rdy/ack handshake.

---
 rtl/sum_stage.sv | 136 +++++++++++++
 tb/tb_sum_stage.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_stage.sv
// sum_stage: per-row accumulate stage between the PE multiply stage and the
// psum-pack stage. Each accepted beat adds the signed multiplier sum to either
// the incoming psum (first beat) or the row accumulator. The active width is
// D8 or D16, and the add saturates or wraps. The last beat of an accumulation
// registers one result beat for the downstream stage.
//
// Handshake (both sides): a producer raises rdy with its data held stable, and
// the consumer raises ack in the same cycle to take it. The transfer happens on
// the clock edge where rdy && ack are both high. On the output side o_SS_rdy
// stays high and o_psum/o_ovf/o_beats/o_SSpipe stay frozen until i_SS_ack.
module sum_stage #(
  parameter int PEROW   = 3,
  parameter int DWD     = 8,
  parameter int PSUMDWD = 16,
  parameter int ASUMDWD = 12,
  parameter int PPW     = 8,
  parameter int CNTW    = 6
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_MS_rdy,
  output logic                              o_MS_ack,
  input  logic [4+PPW-1:0]                  i_pipe,
  input  logic [PEROW-1:0][PSUMDWD-1:0]     i_psum,
  input  logic [PEROW-1:0][ASUMDWD-1:0]     i_sum,
  output logic                              o_SS_rdy,
  input  logic                              i_SS_ack,
  output logic [PEROW-1:0][PSUMDWD-1:0]     o_psum,
  output logic                              o_ovf,
  output logic [CNTW-1:0]                   o_beats,
  output logic [PPW-1:0]                    o_SSpipe
);

  localparam logic [PSUMDWD-1:0] MAX16   = {1'b0, {(PSUMDWD-1){1'b1}}};
  localparam logic [PSUMDWD-1:0] MIN16   = {1'b1, {(PSUMDWD-1){1'b0}}};
  localparam logic [DWD-1:0]     MAX8    = {1'b0, {(DWD-1){1'b1}}};
  localparam logic [DWD-1:0]     MIN8    = {1'b1, {(DWD-1){1'b0}}};
  localparam logic [CNTW-1:0]    CNT_MAX = {CNTW{1'b1}};
  localparam logic [CNTW-1:0]    CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  // Control fields carried with each beat.
  logic           psum_mode;   // 1 = D16, 0 = D8
  logic           acc_first;
  logic           acc_last;
  logic           sat_en;
  logic [PPW-1:0] ssppctl;

  assign psum_mode = i_pipe[PPW+3];
  assign acc_first = i_pipe[PPW+2];
  assign acc_last  = i_pipe[PPW+1];
  assign sat_en    = i_pipe[PPW];
  assign ssppctl   = i_pipe[PPW-1:0];

  logic [PEROW-1:0][PSUMDWD-1:0] acc_reg;
  logic                          ovf_acc;
  logic [CNTW-1:0]               beat_cnt;

  logic [PEROW-1:0][PSUMDWD-1:0] row_res;
  logic [PEROW-1:0]              row_ovf;
  logic                          acc;
  logic                          ovf_next;
  logic [CNTW-1:0]               cnt_next;

  // A beat is taken when the output slot is free or being emptied this cycle;
  // nothing is taken while reset is held.
  assign acc      = i_MS_rdy && (!o_SS_rdy || i_SS_ack) && !i_rst;
  assign o_MS_ack = acc;

  assign ovf_next = (acc_first ? 1'b0 : ovf_acc) | (|row_ovf);
  assign cnt_next = acc_first ? CNT_ONE :
                    (beat_cnt == CNT_MAX) ? beat_cnt : beat_cnt + CNT_ONE;

  for (genvar g = 0; g < PEROW; g++) begin : g_row
    logic [PSUMDWD-1:0] base;
    logic [PSUMDWD:0]   sum_ext;
    logic [PSUMDWD:0]   t16;
    logic [DWD:0]       t8;
    logic [DWD-1:0]     r8;

    assign base    = acc_first ? i_psum[g] : acc_reg[g];
    assign sum_ext = {{(PSUMDWD+1-ASUMDWD){i_sum[g][ASUMDWD-1]}}, i_sum[g]};
    // One guard bit above the active width catches any overflow of the add.
    assign t16     = {base[PSUMDWD-1], base} + sum_ext;
    assign t8      = {base[DWD-1], base[DWD-1:0]} + sum_ext[DWD:0];

    // Select the active width, detect overflow, then clamp or wrap.
    always_comb begin
      row_res[g] = '0;
      row_ovf[g] = 1'b0;
      r8         = '0;
      if (psum_mode) begin
        row_ovf[g] = t16[PSUMDWD] ^ t16[PSUMDWD-1];
        if (row_ovf[g] && sat_en) row_res[g] = t16[PSUMDWD] ? MIN16 : MAX16;
        else                      row_res[g] = t16[PSUMDWD-1:0];
      end else begin
        row_ovf[g] = t8[DWD] ^ t8[DWD-1];
        if (row_ovf[g] && sat_en) r8 = t8[DWD] ? MIN8 : MAX8;
        else                      r8 = t8[DWD-1:0];
        row_res[g] = {{(PSUMDWD-DWD){r8[DWD-1]}}, r8};
      end
    end
  end

  // Accumulator, sticky overflow and beat counter advance on every accepted beat.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc_reg  <= '0;
      ovf_acc  <= 1'b0;
      beat_cnt <= '0;
    end else if (acc) begin
      acc_reg  <= row_res;
      ovf_acc  <= ovf_next;
      beat_cnt <= cnt_next;
    end
  end

  // Output slot: load on an accepted last beat, otherwise drain on ack.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_SS_rdy <= 1'b0;
      o_psum   <= '0;
      o_ovf    <= 1'b0;
      o_beats  <= '0;
      o_SSpipe <= '0;
    end else if (acc && acc_last) begin
      o_SS_rdy <= 1'b1;
      o_psum   <= row_res;
      o_ovf    <= ovf_next;
      o_beats  <= cnt_next;
      o_SSpipe <= ssppctl;
    end else if (i_SS_ack) begin
      o_SS_rdy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sum_stage.sv
// Bench for sum_stage: directed scenarios from the behaviour description plus
// a randomized run, all checked against an integer reference model.
module tb_sum_stage;
  localparam int PEROW   = 3;
  localparam int DWD     = 8;
  localparam int PSUMDWD = 16;
  localparam int ASUMDWD = 12;
  localparam int PPW     = 8;
  localparam int CNTW    = 6;
  localparam int VW      = 1 + PEROW*PSUMDWD + 1 + CNTW + PPW;

  logic                          i_clk = 1'b0;
  logic                          i_rst = 1'b1;
  logic                          i_MS_rdy = 1'b0;
  logic                          o_MS_ack;
  logic [4+PPW-1:0]              i_pipe = '0;
  logic [PEROW-1:0][PSUMDWD-1:0] i_psum = '0;
  logic [PEROW-1:0][ASUMDWD-1:0] i_sum = '0;
  logic                          o_SS_rdy;
  logic                          i_SS_ack = 1'b0;
  logic [PEROW-1:0][PSUMDWD-1:0] o_psum;
  logic                          o_ovf;
  logic [CNTW-1:0]               o_beats;
  logic [PPW-1:0]                o_SSpipe;

  sum_stage #(
    .PEROW(PEROW), .DWD(DWD), .PSUMDWD(PSUMDWD),
    .ASUMDWD(ASUMDWD), .PPW(PPW), .CNTW(CNTW)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_MS_rdy(i_MS_rdy), .o_MS_ack(o_MS_ack),
    .i_pipe(i_pipe), .i_psum(i_psum), .i_sum(i_sum), .o_SS_rdy(o_SS_rdy),
    .i_SS_ack(i_SS_ack), .o_psum(o_psum), .o_ovf(o_ovf), .o_beats(o_beats),
    .o_SSpipe(o_SSpipe)
  );

  // Clock
  always #5 i_clk = ~i_clk;

  // Stimulus values for the next beat (plain signed integers per row).
  int ps_v[PEROW];
  int sm_v[PEROW];

  // Reference model state.
  int m_acc[PEROW];
  bit m_ovf_acc;
  int m_cnt;
  bit m_rdy;
  int m_psum[PEROW];
  bit m_ovf;
  int m_beats;
  int m_pipe;

  bit obs_ack, exp_ack;
  int pass_cnt = 0;
  int total_cnt = 0;
  logic [VW-1:0] held;

  function automatic logic [VW-1:0] obs_vec();
    return {o_SS_rdy, o_psum, o_ovf, o_beats, o_SSpipe};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {m_rdy, 16'(m_psum[2]), 16'(m_psum[1]), 16'(m_psum[0]),
            m_ovf, 6'(m_beats), 8'(m_pipe)};
  endfunction

  function automatic void model_reset();
    for (int r = 0; r < PEROW; r++) begin
      m_acc[r]  = 0;
      m_psum[r] = 0;
    end
    m_ovf_acc = 0; m_cnt = 0; m_rdy = 0; m_ovf = 0; m_beats = 0; m_pipe = 0;
  endfunction

  // Integer-arithmetic model of one accepted beat.
  function automatic void model_beat(bit mode, bit first, bit last, bit sat, int pp);
    bit any = 0;
    int res[PEROW];
    for (int r = 0; r < PEROW; r++) begin
      int base, t, lo, hi;
      base = first ? int'(shortint'(ps_v[r])) : m_acc[r];
      if (mode) begin
        t = base + sm_v[r]; lo = -32768; hi = 32767;
      end else begin
        t = int'(byte'(base)) + sm_v[r]; lo = -128; hi = 127;
      end
      if (t < lo || t > hi) begin
        any = 1;
        if (sat) t = (t < lo) ? lo : hi;
        else     t = mode ? int'(shortint'(t)) : int'(byte'(t));
      end
      res[r] = t;
    end
    m_acc     = res;
    m_ovf_acc = (first ? 1'b0 : m_ovf_acc) | any;
    m_cnt     = first ? 1 : ((m_cnt + 1 > 63) ? 63 : m_cnt + 1);
    if (last) begin
      m_psum  = res;
      m_ovf   = m_ovf_acc;
      m_beats = m_cnt;
      m_pipe  = pp & 8'hFF;
      m_rdy   = 1;
    end
  endfunction

  // Driver: entered just after a falling edge, drives one cycle, returns just
  // after the next falling edge with the registered outputs settled.
  task automatic step(bit rdy, bit mode, bit first, bit last, bit sat, int pp, bit ssack);
    i_MS_rdy = rdy;
    i_pipe   = {mode, first, last, sat, 8'(pp)};
    for (int r = 0; r < PEROW; r++) begin
      i_psum[r] = 16'(ps_v[r]);
      i_sum[r]  = 12'(sm_v[r]);
    end
    i_SS_ack = ssack;
    #1;
    obs_ack = o_MS_ack;
    exp_ack = rdy && (!m_rdy || ssack);
    @(posedge i_clk);
    if (exp_ack) model_beat(mode, first, last, sat, pp);
    if (!(exp_ack && last) && ssack) m_rdy = 0;
    @(negedge i_clk);
  endtask

  task automatic rand_rows16();
    for (int r = 0; r < PEROW; r++) begin
      ps_v[r] = int'($urandom_range(0, 65535));
      sm_v[r] = int'($urandom_range(0, 4095)) - 2048;
    end
  endtask

  task automatic test_reset();
    model_reset();
    i_MS_rdy = 1; i_SS_ack = 1;
    i_pipe = {1'b1, 1'b1, 1'b1, 1'b0, 8'h5A};
    repeat (2) @(negedge i_clk);
    total_cnt++;
    if (obs_vec() !== '0) $display("FAIL reset_outputs got %h want 0", obs_vec());
    else pass_cnt++;
    total_cnt++;
    if (o_MS_ack !== 1'b0) $display("FAIL reset_ack got %b want 0", o_MS_ack);
    else pass_cnt++;
    i_rst = 0; i_MS_rdy = 0; i_SS_ack = 0;
    @(negedge i_clk);
  endtask

  task automatic test_single_d16();
    rand_rows16();
    ps_v[0] = 1000; sm_v[0] = -24;
    step(1, 1, 1, 1, 0, 8'hA5, 1);
    total_cnt++;
    if (obs_ack !== 1'b1) $display("FAIL single_ack got %b want 1", obs_ack);
    else pass_cnt++;
    total_cnt++;
    if (o_psum[0] !== 16'd976 || o_beats !== 6'd1 || o_ovf !== 1'b0 || o_SS_rdy !== 1'b1)
      $display("FAIL single_row0 got psum=%0d beats=%0d ovf=%b rdy=%b want 976 1 0 1",
               $signed(o_psum[0]), o_beats, o_ovf, o_SS_rdy);
    else pass_cnt++;
    total_cnt++;
    if (obs_vec() !== exp_vec()) $display("FAIL single_vec got %h want %h", obs_vec(), exp_vec());
    else pass_cnt++;
    step(0, 1, 1, 1, 0, 0, 1);
    total_cnt++;
    if (obs_vec() !== exp_vec() || o_SS_rdy !== 1'b0)
      $display("FAIL single_drain got %h want %h", obs_vec(), exp_vec());
    else pass_cnt++;
  endtask

  task automatic test_accumulate();
    int sums[3] = '{5, 6, 7};
    for (int b = 0; b < 3; b++) begin
      rand_rows16();
      ps_v[0] = 10; sm_v[0] = sums[b];
      step(1, 1, b == 0, b == 2, 1, 8'h30 + b, 1);
      if (b < 2) begin
        total_cnt++;
        if (o_SS_rdy !== 1'b0) $display("FAIL accum_midrdy beat %0d got %b want 0", b, o_SS_rdy);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (o_psum[0] !== 16'd28 || o_beats !== 6'd3 || o_SS_rdy !== 1'b1 || o_SSpipe !== 8'h32)
      $display("FAIL accum_result got psum=%0d beats=%0d rdy=%b pp=%h want 28 3 1 32",
               $signed(o_psum[0]), o_beats, o_SS_rdy, o_SSpipe);
    else pass_cnt++;
    total_cnt++;
    if (obs_vec() !== exp_vec()) $display("FAIL accum_vec got %h want %h", obs_vec(), exp_vec());
    else pass_cnt++;
  endtask

  task automatic test_d8_sat();
    for (int r = 0; r < PEROW; r++) begin ps_v[r] = 0; sm_v[r] = r; end
    ps_v[0] = 32'h3A78; sm_v[0] = 20;
    step(1, 0, 1, 1, 1, 8'h11, 1);
    total_cnt++;
    if (o_psum[0] !== 16'h007F || o_ovf !== 1'b1)
      $display("FAIL d8_sat got psum=%h ovf=%b want 007f 1", o_psum[0], o_ovf);
    else pass_cnt++;
    step(1, 0, 1, 1, 0, 8'h12, 1);
    total_cnt++;
    if (o_psum[0] !== 16'hFF8C || o_ovf !== 1'b1)
      $display("FAIL d8_wrap got psum=%h ovf=%b want ff8c 1", o_psum[0], o_ovf);
    else pass_cnt++;
    total_cnt++;
    if (obs_vec() !== exp_vec()) $display("FAIL d8_vec got %h want %h", obs_vec(), exp_vec());
    else pass_cnt++;
  endtask

  task automatic test_d16_clamp();
    for (int r = 0; r < PEROW; r++) begin ps_v[r] = 0; sm_v[r] = 0; end
    ps_v[0] = -32760; sm_v[0] = -100;
    step(1, 1, 1, 1, 1, 8'h21, 1);
    total_cnt++;
    if (o_psum[0] !== 16'h8000 || o_ovf !== 1'b1)
      $display("FAIL d16_clamp got psum=%h ovf=%b want 8000 1", o_psum[0], o_ovf);
    else pass_cnt++;
    for (int r = 0; r < PEROW; r++) begin ps_v[r] = 5; sm_v[r] = 5; end
    step(1, 1, 1, 1, 1, 8'h22, 1);
    total_cnt++;
    if (o_psum[0] !== 16'd10 || o_ovf !== 1'b0)
      $display("FAIL d16_ovf_clear got psum=%h ovf=%b want 000a 0", o_psum[0], o_ovf);
    else pass_cnt++;
  endtask

  task automatic test_beat_sat();
    for (int r = 0; r < PEROW; r++) begin ps_v[r] = 0; sm_v[r] = 0; end
    step(1, 1, 1, 0, 0, 0, 1);
    for (int i = 0; i < 70; i++) step(1, 1, 0, 0, 0, 0, 1);
    step(1, 1, 0, 1, 0, 8'h77, 1);
    total_cnt++;
    if (o_beats !== 6'd63) $display("FAIL beat_sat got %0d want 63", o_beats);
    else pass_cnt++;
    total_cnt++;
    if (obs_vec() !== exp_vec()) $display("FAIL beat_sat_vec got %h want %h", obs_vec(), exp_vec());
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    rand_rows16();
    step(1, 1, 1, 1, 0, 8'h40, 1);
    held = obs_vec();
    for (int i = 0; i < 4; i++) begin
      rand_rows16();
      step(1, 1, 1, i % 2, 0, 8'h50 + i, 0);
      total_cnt++;
      if (obs_ack !== 1'b0 || obs_vec() !== held)
        $display("FAIL stall cyc %0d ack=%b got %h want %h", i, obs_ack, obs_vec(), held);
      else pass_cnt++;
    end
    for (int i = 0; i < 2; i++) begin
      rand_rows16();
      step(1, 1, 1, 1, 0, 8'h60 + i, 1);
      total_cnt++;
      if (obs_ack !== 1'b1 || o_SS_rdy !== 1'b1 || obs_vec() !== exp_vec())
        $display("FAIL b2b %0d ack=%b got %h want %h", i, obs_ack, obs_vec(), exp_vec());
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    rand_rows16();
    step(1, 1, 1, 0, 0, 8'h01, 1);
    i_MS_rdy = 1;
    #2 i_rst = 1;
    #1;
    model_reset();
    total_cnt++;
    if (obs_vec() !== '0 || o_MS_ack !== 1'b0)
      $display("FAIL rst_mid got %h ack=%b want 0 0", obs_vec(), o_MS_ack);
    else pass_cnt++;
    @(negedge i_clk);
    i_rst = 0;
    for (int r = 0; r < PEROW; r++) begin
      ps_v[r] = int'($urandom_range(0, 65535)); sm_v[r] = 5;
    end
    step(1, 1, 0, 1, 0, 8'h02, 1);
    total_cnt++;
    if (o_psum[0] !== 16'd5 || o_psum[2] !== 16'd5 || o_beats !== 6'd1)
      $display("FAIL rst_after got psum=%0d beats=%0d want 5 1", $signed(o_psum[0]), o_beats);
    else pass_cnt++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bit mode = 1'($urandom_range(0, 1));
      for (int r = 0; r < PEROW; r++) begin
        ps_v[r] = int'($urandom_range(0, 65535));
        sm_v[r] = mode ? int'($urandom_range(0, 4095)) - 2048
                       : int'($urandom_range(0, 255)) - 128;
      end
      step($urandom_range(0, 3) != 0, mode, $urandom_range(0, 2) == 0,
           $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 255)), $urandom_range(0, 2) != 0);
      total_cnt++;
      if (obs_ack !== exp_ack || obs_vec() !== exp_vec())
        $display("FAIL random %0d ack=%b/%b got %h want %h", i, obs_ack, exp_ack, obs_vec(), exp_vec());
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_single_d16();
    test_accumulate();
    test_d8_sat();
    test_d16_clamp();
    test_beat_sat();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
